// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/response bundle between the pipeline stages and
// the hazard controller. The pipeline side uses the master modport, the
// controller uses the slave modport.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4,
  parameter int SEL_W  = 3
);
  logic [STAGES-1:0] req_stall;
  logic              hold_req;
  logic [SEL_W-1:0]  hold_stage;
  logic [CNT_W-1:0]  hold_len;
  logic              flush_req;
  logic [ADDR_W-1:0] flush_pc;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output req_stall, hold_req, hold_stage, hold_len, flush_req, flush_pc,
    input  stall, flush, redirect_valid, redirect_pc, busy,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  req_stall, hold_req, hold_stage, hold_len, flush_req, flush_pc,
    output stall, flush, redirect_valid, redirect_pc, busy,
           perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller. Merges per-stage stall requests
// into a thermometer stall vector, runs timed multi-cycle holds for
// iterative units, and issues branch flushes with a held PC redirect.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush perf counters.
module pipe_ctrl #(
  parameter int STAGES      = 6,
  parameter int FLUSH_STAGE = 2,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 4,
  parameter int SEL_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  // Stages below the branch-resolving stage; the flush kills 1..FLUSH_STAGE-1.
  localparam logic [STAGES-1:0] LO_MASK    = STAGES'((1 << FLUSH_STAGE) - 1);
  localparam logic [STAGES-1:0] FLUSH_MASK = LO_MASK & ~STAGES'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SEL_W-1:0]  hold_stage_reg, hold_stage_nxt;
  logic              hold_acc;
  logic              flush_acc;
  logic [STAGES-1:0] req_all;
  logic [STAGES-1:0] req_eff;
  logic [STAGES-1:0] stall_raw;
  logic [STAGES-1:0] stall_eff;
  logic              redirect_valid_q;
  logic [ADDR_W-1:0] redirect_pc_q;

  // Bit j set when any request at index >= j is present.
  function automatic logic [STAGES-1:0] therm(input logic [STAGES-1:0] r);
    logic [STAGES-1:0] t;
    t = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      t[j] = |(r >> j);
    end
    return t;
  endfunction

  // Merge level requests, the active hold and a hold accepted this cycle.
  always_comb begin
    hold_acc = bus.hold_req && (state == IDLE) && (bus.hold_len != '0);
    req_all  = bus.req_stall;
    for (int unsigned j = 0; j < STAGES; j++) begin
      if ((state == HOLD) && (hold_stage_reg == SEL_W'(j))) req_all[j] = 1'b1;
      if (hold_acc && (bus.hold_stage == SEL_W'(j)))         req_all[j] = 1'b1;
    end
  end

  // Flush acceptance and final stall/flush vectors, forced low in reset.
  always_comb begin
    stall_raw = therm(req_all);
    flush_acc = rst && bus.flush_req && !stall_raw[FLUSH_STAGE];
    req_eff   = flush_acc ? (req_all & ~LO_MASK) : req_all;
    stall_eff = rst ? therm(req_eff) : '0;
  end

  // Hold FSM next-state and counter logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hold_stage_nxt = hold_stage_reg;
    case (state)
      IDLE: begin
        // A hold whose stage is flushed in its own request cycle is dropped.
        if (hold_acc && (bus.hold_len >= CNT_W'(2)) &&
            !(flush_acc && (bus.hold_stage < SEL_W'(FLUSH_STAGE)))) begin
          state_nxt      = HOLD;
          cnt_nxt        = bus.hold_len - CNT_W'(1);
          hold_stage_nxt = bus.hold_stage;
        end
      end
      HOLD: begin
        if (flush_acc && (hold_stage_reg < SEL_W'(FLUSH_STAGE))) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Hold FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      hold_stage_reg <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      hold_stage_reg <= hold_stage_nxt;
    end
  end

  // Redirect flag: set on accepted flush (wins), cleared when PC stage runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else if (flush_acc) begin
      redirect_valid_q <= 1'b1;
      redirect_pc_q    <= bus.flush_pc;
    end else if (redirect_valid_q && !stall_eff[0]) begin
      redirect_valid_q <= 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running wrap-around counters of PC-stall cycles and accepted flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_eff[0]) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_acc)    perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_flush_cnt = '0;
`endif

  assign bus.stall          = stall_eff;
  assign bus.flush          = flush_acc ? FLUSH_MASK : '0;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.busy           = rst && ((state == HOLD) || redirect_valid_q);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. Each step drives one cycle
// of inputs and queues the expected outputs; a negedge monitor pops and checks.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl_if #(.STAGES(6), .ADDR_W(32), .CNT_W(4), .SEL_W(3)) bus ();

  pipe_ctrl #(
    .STAGES(6), .FLUSH_STAGE(2), .ADDR_W(32), .CNT_W(4), .SEL_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue expected outputs, advance to next cycle.
  task automatic step(input string tag, input logic [5:0] rs,
                      input logic hr, input logic [2:0] hs, input logic [3:0] hl,
                      input logic fr, input logic [31:0] fpc,
                      input logic [5:0] es, input logic [5:0] ef,
                      input logic erv, input logic [31:0] erpc, input logic eb);
    exp_t e;
    bus.req_stall  = rs;
    bus.hold_req   = hr;
    bus.hold_stage = hs;
    bus.hold_len   = hl;
    bus.flush_req  = fr;
    bus.flush_pc   = fpc;
    e.tag = tag; e.stall = es; e.flush = ef; e.rv = erv; e.rpc = erpc; e.busy = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, ".stall"}, 64'(bus.stall),          64'(e.stall));
      check_eq({e.tag, ".flush"}, 64'(bus.flush),          64'(e.flush));
      check_eq({e.tag, ".rv"},    64'(bus.redirect_valid), 64'(e.rv));
      check_eq({e.tag, ".rpc"},   64'(bus.redirect_pc),    64'(e.rpc));
      check_eq({e.tag, ".busy"},  64'(bus.busy),           64'(e.busy));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.req_stall = '0; bus.hold_req = 1'b0; bus.hold_stage = '0;
    bus.hold_len = '0; bus.flush_req = 1'b0; bus.flush_pc = '0;
    @(posedge clk);
    #1;
    //          tag       rs         hr hs  hl  fr fpc        stall      flush      rv rpc        busy
    step("rst",      6'b111111, 1, 3, 4, 1, 32'h55,  6'b000000, 6'b000000, 0, 32'h0,   0);
    rst = 1'b1;
    step("idle",     6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,   0);
    step("rs4",      6'b000100, 0, 0, 0, 0, 32'h0,   6'b000111, 6'b000000, 0, 32'h0,   0);
    step("rs10",     6'b001010, 0, 0, 0, 0, 32'h0,   6'b001111, 6'b000000, 0, 32'h0,   0);
    step("rs0",      6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,   0);
    step("h_c1",     6'b000000, 1, 3, 4, 0, 32'h0,   6'b001111, 6'b000000, 0, 32'h0,   0);
    step("h_c2",     6'b000000, 1, 0, 8, 0, 32'h0,   6'b001111, 6'b000000, 0, 32'h0,   1);
    step("h_c3",     6'b000000, 0, 0, 0, 0, 32'h0,   6'b001111, 6'b000000, 0, 32'h0,   1);
    step("h_c4",     6'b000000, 0, 0, 0, 0, 32'h0,   6'b001111, 6'b000000, 0, 32'h0,   1);
    step("h_end",    6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,   0);
    step("fl",       6'b000010, 0, 0, 0, 1, 32'h100, 6'b000000, 6'b000010, 0, 32'h0,   0);
    step("fl_rv",    6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 1, 32'h100, 1);
    step("fl_clr",   6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h100, 0);
    step("fl2",      6'b000000, 0, 0, 0, 1, 32'h200, 6'b000000, 6'b000010, 0, 32'h100, 0);
    step("rv_hold",  6'b000001, 0, 0, 0, 0, 32'h0,   6'b000001, 6'b000000, 1, 32'h200, 1);
    step("rv_rel",   6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 1, 32'h200, 1);
    step("rv_done",  6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h200, 0);
    step("fl3",      6'b000000, 0, 0, 0, 1, 32'h300, 6'b000000, 6'b000010, 0, 32'h200, 0);
    step("fl4",      6'b000000, 0, 0, 0, 1, 32'h400, 6'b000000, 6'b000010, 1, 32'h300, 1);
    step("ovr",      6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 1, 32'h400, 1);
    step("ovr_clr",  6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h400, 0);
    step("flrej",    6'b001000, 0, 0, 0, 1, 32'h500, 6'b001111, 6'b000000, 0, 32'h400, 0);
    step("flrej2",   6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h400, 0);
    step("len1",     6'b000000, 1, 4, 1, 0, 32'h0,   6'b011111, 6'b000000, 0, 32'h400, 0);
    step("len1_end", 6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h400, 0);
    step("len0",     6'b000000, 1, 5, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h400, 0);
    step("hc_c1",    6'b000000, 1, 1, 8, 0, 32'h0,   6'b000011, 6'b000000, 0, 32'h400, 0);
    step("hc_c2",    6'b000000, 0, 0, 0, 0, 32'h0,   6'b000011, 6'b000000, 0, 32'h400, 1);
    step("hc_fl",    6'b000000, 0, 0, 0, 1, 32'h600, 6'b000000, 6'b000010, 0, 32'h400, 1);
    step("hc_after", 6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 1, 32'h600, 1);
    step("hc_done",  6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h600, 0);
    step("rs_fl",    6'b000000, 0, 0, 0, 1, 32'h700, 6'b000000, 6'b000010, 0, 32'h600, 0);
    step("rs_h1",    6'b000000, 1, 3, 8, 0, 32'h0,   6'b001111, 6'b000000, 1, 32'h700, 1);
    step("rs_h2",    6'b000000, 0, 0, 0, 0, 32'h0,   6'b001111, 6'b000000, 1, 32'h700, 1);
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf_stall", 64'(bus.perf_stall_cnt), 64'd13);
    check_eq("perf_flush", 64'(bus.perf_flush_cnt), 64'd6);
`else
    check_eq("perf_stall", 64'(bus.perf_stall_cnt), 64'd0);
    check_eq("perf_flush", 64'(bus.perf_flush_cnt), 64'd0);
`endif
    rst = 1'b0;
    step("rs_mid",   6'b000100, 1, 3, 4, 1, 32'h800, 6'b000000, 6'b000000, 0, 32'h0,   0);
    rst = 1'b1;
    step("rs_post",  6'b000000, 0, 0, 0, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,   0);
    check_eq("perf_stall_rst", 64'(bus.perf_stall_cnt), 64'd0);
    check_eq("perf_flush_rst", 64'(bus.perf_flush_cnt), 64'd0);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
